// File: rtl/int_para_pf_encoder_pkg.sv
// Shared definitions for the integer-to-float encoder and the float adder:
// FSM states, status codes, field bounds of the 32-bit float word and the exponent bias.
package pf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ABS  = 2'd1,
    NORM = 2'd2,
    HOLD = 2'd3
  } enc_state_t;

  localparam logic [3:0] ST_EXACT     = 4'd0;
  localparam logic [3:0] ST_OVERFLOW  = 4'd1;
  localparam logic [3:0] ST_UNDERFLOW = 4'd2;
  localparam logic [3:0] ST_INEXACT   = 4'd3;

  // Bit 0 is the MSB of every float word.
  localparam int SIGN_BIT = 0;
  localparam int EXP_MSB  = 1;
  localparam int EXP_LSB  = 6;
  localparam int FRAC_MSB = 7;
  localparam int FRAC_LSB = 31;

  localparam int PF_BIAS = 31;

endpackage

// File: rtl/int_para_pf_encoder_if.sv
// Handshake bundle between an integer source/result consumer and the encoder.
// The encoder uses the slave modport; the source/consumer side uses master.
interface int_para_pf_encoder_if;
  logic [0:31] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] data_out;
  logic [0:3]  status_out;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, data_out, status_out, out_valid
  );

  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, data_out, status_out, out_valid
  );
endinterface

// File: rtl/int_para_pf_encoder.sv
// Converts a 32-bit two's-complement integer to the 32-bit float format, normalising one bit
// per clock (2..33 cycles); result is held until out_ready, and no new input is taken meanwhile.
module int_para_pf_encoder
  import pf_pkg::*;
#(
  parameter int BIAS = PF_BIAS
) (
  input  logic                   clock_100kHz,
  input  logic                   reset,
  int_para_pf_encoder_if.slave   enc
);

  // Exponent of a magnitude whose MSB sits at bit 0 of the unshifted word.
  localparam logic [5:0] EXP_TOP = 6'(BIAS + 31);

  enc_state_t  state_q, state_d;
  logic [0:31] x_q, x_d;
  logic [0:31] mag_q, mag_d;
  logic [5:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [0:31] dout_q, dout_d;
  logic [3:0]  st_q, st_d;

  logic mag_zero;
  logic mag_norm;

  assign mag_zero = (mag_q == '0);
  assign mag_norm = mag_q[0];

  // State register
  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enc.in_valid)           state_d = ABS;
      ABS:                              state_d = NORM;
      NORM: if (mag_zero || mag_norm)   state_d = HOLD;
      HOLD: if (enc.out_ready)          state_d = IDLE;
      default:                          state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    enc.in_ready   = (state_q == IDLE) && !reset;
    enc.out_valid  = (state_q == HOLD);
    enc.data_out   = dout_q;
    enc.status_out = st_q;
  end

  always_comb begin
    x_d    = x_q;
    mag_d  = mag_q;
    exp_d  = exp_q;
    sign_d = sign_q;
    dout_d = dout_q;
    st_d   = st_q;
    unique case (state_q)
      IDLE: begin
        if (enc.in_valid) x_d = enc.data_in;
      end
      ABS: begin
        // -2^31 negates to itself, which is the right unsigned magnitude.
        sign_d = x_q[0];
        mag_d  = x_q[0] ? (~x_q + 32'd1) : x_q;
        exp_d  = EXP_TOP;
      end
      NORM: begin
        if (mag_zero) begin
          dout_d = '0;
          st_d   = ST_EXACT;
        end else if (!mag_norm) begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 6'd1;
        end else begin
          // The leading 1 is hidden; bits below the fraction are truncated.
          dout_d[SIGN_BIT]          = sign_q;
          dout_d[EXP_MSB:EXP_LSB]   = exp_q;
          dout_d[FRAC_MSB:FRAC_LSB] = mag_q[1:25];
          st_d = (mag_q[26:31] != '0) ? ST_INEXACT : ST_EXACT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      x_q    <= '0;
      mag_q  <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
      dout_q <= '0;
      st_q   <= ST_EXACT;
    end else begin
      x_q    <= x_d;
      mag_q  <= mag_d;
      exp_q  <= exp_d;
      sign_q <= sign_d;
      dout_q <= dout_d;
      st_q   <= st_d;
    end
  end

endmodule

// File: tb/tb_int_para_pf_encoder.sv
// Bench for int_para_pf_encoder: directed vectors, backpressure, reset mid-conversion and
// random traffic, all checked every cycle against an arithmetic model of the conversion.
module tb_int_para_pf_encoder;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int_para_pf_encoder_if enc_if ();

  int_para_pf_encoder dut (
    .clock_100kHz (clk),
    .reset        (rst),
    .enc          (enc_if)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp_v);
    end
  endtask

  // Value-level model: find the top set bit of |x|, the rest of the magnitude becomes the fraction.
  task automatic model(input logic [31:0] x, output logic [31:0] d, output logic [3:0] st,
                       output int lat);
    logic        s;
    logic [32:0] m;
    logic [32:0] f;
    logic [30:0] f31;
    int          p;
    s = x[31];
    m = s ? (33'h1_0000_0000 - {1'b0, x}) : {1'b0, x};
    if (m == 0) begin
      d = 32'h0; st = 4'd0; lat = 2;
    end else begin
      p = 0;
      for (int i = 0; i < 33; i++) if (m[i]) p = i;
      f   = m - (33'd1 << p);
      f31 = 31'(f << (31 - p));
      d   = {s, 6'(31 + p), f31[30:6]};
      st  = (f31[5:0] != 6'd0) ? 4'd3 : 4'd0;
      lat = 2 + 31 - p;
    end
  endtask

  // Per-cycle scoreboard
  logic        started = 1'b0;
  logic        busy = 1'b0;
  int          due = 0;
  int          m_lat;
  logic [31:0] exp_d = '0, last_d = '0;
  logic [3:0]  exp_s = '0, last_s = '0;
  logic        ev;

  always @(negedge clk) begin
    if (started) begin
      ev = busy && (cyc >= due);
      chk("in_ready",   64'(enc_if.in_ready),   64'(!rst && !busy));
      chk("out_valid",  64'(enc_if.out_valid),  64'(ev));
      chk("data_out",   64'(enc_if.data_out),   64'(ev ? exp_d : last_d));
      chk("status_out", 64'(enc_if.status_out), 64'(ev ? exp_s : last_s));
    end
    if (rst) begin
      busy = 1'b0; last_d = '0; last_s = '0; started = 1'b1;
    end else if (started) begin
      if (!busy && enc_if.in_valid && enc_if.in_ready) begin
        model(enc_if.data_in, exp_d, exp_s, m_lat);
        due  = cyc + 1 + m_lat;
        busy = 1'b1;
      end else if (busy && cyc >= due && enc_if.out_ready) begin
        busy = 1'b0; last_d = exp_d; last_s = exp_s;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (enc_if.in_ready) ok = 1'b1;
    end
    if (!ok) chk("timeout_in_ready", 64'd0, 64'd1);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (enc_if.out_valid) ok = 1'b1;
    end
    if (!ok) chk("timeout_out_valid", 64'd0, 64'd1);
  endtask

  task automatic release_result();
    @(posedge clk); #1 enc_if.out_ready = 1'b1;
    @(posedge clk); #1 enc_if.out_ready = 1'b0;
  endtask

  task automatic run_dir(input logic [31:0] x, input logic [31:0] ed, input logic [3:0] es,
                         input int el);
    int t0;
    bit ok;
    @(posedge clk); #1;
    enc_if.data_in = x; enc_if.in_valid = 1'b1; enc_if.out_ready = 1'b0;
    wait_ready(ok);
    t0 = cyc + 1;
    @(posedge clk); #1 enc_if.in_valid = 1'b0;
    if (ok) begin
      wait_valid(ok);
      if (ok) begin
        chk("dir_latency", 64'(cyc - t0), 64'(el));
        chk("dir_data",    64'(enc_if.data_out), 64'(ed));
        chk("dir_status",  64'(enc_if.status_out), 64'(es));
      end
    end
    release_result();
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] r;
    int          sh;
    r  = $urandom;
    sh = $urandom_range(0, 33);
    if (sh == 33)      r = 32'h8000_0000;
    else if (sh == 32) r = 32'h0;
    else               r = r >> sh;
    if ($urandom_range(0, 1) == 1) r = -r;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] md;
    logic [3:0]  ms;
    int          ml;
    logic [31:0] held;
    logic [31:0] nxt;
    bit          ok;
    bit          took;
    int          seen;
    int          n_acc;

    rst = 1'b1;
    enc_if.data_in = '0; enc_if.in_valid = 1'b0; enc_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed points that pin the model
    model(32'h0000_0001, md, ms, ml);
    chk("model_one_d", 64'(md), 64'h3E00_0000); chk("model_one_lat", 64'(ml), 64'd33);
    model(32'hFFFF_FFFA, md, ms, ml);
    chk("model_m6_d", 64'(md), 64'hC300_0000);  chk("model_m6_lat", 64'(ml), 64'd31);
    model(32'h7FFF_FFFF, md, ms, ml);
    chk("model_max_d", 64'(md), 64'h7BFF_FFFF); chk("model_max_st", 64'(ms), 64'd3);
    model(32'h8000_0000, md, ms, ml);
    chk("model_min_d", 64'(md), 64'hFC00_0000); chk("model_min_lat", 64'(ml), 64'd2);

    run_dir(32'h0000_0001, 32'h3E00_0000, 4'd0, 33);
    run_dir(32'hFFFF_FFFA, 32'hC300_0000, 4'd0, 31);
    run_dir(32'h7FFF_FFFF, 32'h7BFF_FFFF, 4'd3, 3);
    run_dir(32'h8000_0000, 32'hFC00_0000, 4'd0, 2);
    run_dir(32'h0000_0000, 32'h0000_0000, 4'd0, 2);

    // Backpressure: result held for 10 cycles while a new word waits
    nxt = 32'h0000_0055;
    @(posedge clk); #1;
    enc_if.data_in = 32'h0001_2345; enc_if.in_valid = 1'b1;
    wait_ready(ok);
    @(posedge clk); #1 enc_if.data_in = nxt;
    wait_valid(ok);
    held = enc_if.data_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_data_stable", 64'(enc_if.data_out), 64'(held));
      chk("bp_in_ready",    64'(enc_if.in_ready), 64'd0);
      chk("bp_out_valid",   64'(enc_if.out_valid), 64'd1);
    end
    @(posedge clk); #1 enc_if.out_ready = 1'b1;
    @(posedge clk); #1 enc_if.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after", 64'(enc_if.in_ready), 64'd1);
    @(posedge clk); #1 enc_if.in_valid = 1'b0;
    wait_valid(ok);
    model(nxt, md, ms, ml);
    chk("bp_next_word", 64'(enc_if.data_out), 64'(md));
    release_result();

    // Reset in the middle of normalising 1
    @(posedge clk); #1;
    enc_if.data_in = 32'h0000_0001; enc_if.in_valid = 1'b1;
    wait_ready(ok);
    @(posedge clk); #1 enc_if.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(enc_if.out_valid), 64'd0);
    chk("rst_data_out",  64'(enc_if.data_out), 64'd0);
    chk("rst_status",    64'(enc_if.status_out), 64'd0);
    chk("rst_in_ready",  64'(enc_if.in_ready), 64'd1);
    enc_if.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (enc_if.out_valid) seen++;
    end
    chk("rst_no_result", 64'(seen), 64'd0);

    // Random traffic with random gaps and random consumer stalls
    n_acc = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      took = enc_if.in_valid && enc_if.in_ready;
      if (took) n_acc++;
      @(posedge clk); #1;
      if (!enc_if.in_valid || took) begin
        enc_if.in_valid = ($urandom_range(0, 2) != 0);
        enc_if.data_in  = gen();
      end
      enc_if.out_ready = ($urandom_range(0, 3) != 0);
    end
    enc_if.in_valid = 1'b0; enc_if.out_ready = 1'b1;
    repeat (50) @(posedge clk);
    chk("rand_traffic", 64'(n_acc > 20), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
